// File: rtl/universal_reg.sv
// Multi-mode WIDTH-bit register: load, shift, rotate, inc/dec, synchronous clear,
// serial in/out, and registered status pulses (changed, wrap) for sequencing logic.
module universal_reg #(
    parameter int                WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             sout,
    output logic             changed,
    output logic             wrap
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROTL = 3'b100,
        MODE_ROTR = 3'b101,
        MODE_INC  = 3'b110,
        MODE_DEC  = 3'b111
    } mode_t;

    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONES_C = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};

    logic [WIDTH-1:0] next_q_s;
    logic             next_sout_s;
    logic             next_wrap_s;
    mode_t            mode_s;

    assign mode_s = mode_t'(mode);

    // Next-state selection: clr beats en, en=0 holds, otherwise decode mode.
    always_comb begin
        next_q_s    = q;
        next_sout_s = sout;
        next_wrap_s = 1'b0;
        if (clr) begin
            next_q_s    = RESET_VAL;
            next_sout_s = 1'b0;
        end else if (!en) begin
            next_q_s    = q;
        end else begin
            case (mode_s)
                MODE_HOLD: next_q_s = q;
                MODE_LOAD: next_q_s = d;
                MODE_SHL: begin
                    next_q_s    = {q[WIDTH-2:0], sin};
                    next_sout_s = q[WIDTH-1];
                end
                MODE_SHR: begin
                    next_q_s    = {sin, q[WIDTH-1:1]};
                    next_sout_s = q[0];
                end
                MODE_ROTL: begin
                    next_q_s    = {q[WIDTH-2:0], q[WIDTH-1]};
                    next_sout_s = q[WIDTH-1];
                end
                MODE_ROTR: begin
                    next_q_s    = {q[0], q[WIDTH-1:1]};
                    next_sout_s = q[0];
                end
                MODE_INC: begin
                    next_q_s    = q + ONE_C;
                    next_wrap_s = (q == ONES_C);
                end
                MODE_DEC: begin
                    next_q_s    = q - ONE_C;
                    next_wrap_s = (q == ZERO_C);
                end
                default: next_q_s = q;
            endcase
        end
    end

    // State and status registers; qb is stored alongside q so it never lags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q       <= RESET_VAL;
            qb      <= ~RESET_VAL;
            sout    <= 1'b0;
            changed <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            q       <= next_q_s;
            qb      <= ~next_q_s;
            sout    <= next_sout_s;
            changed <= (next_q_s != q);
            wrap    <= next_wrap_s;
        end
    end

endmodule

// File: tb/tb_universal_reg.sv
// Randomised and directed bench for universal_reg (WIDTH=8, RESET_VAL=0) against an
// arithmetic reference model.
module tb_universal_reg;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         clr;
    logic [2:0]   mode;
    logic [W-1:0] d;
    logic         sin;
    logic [W-1:0] q;
    logic [W-1:0] qb;
    logic         sout;
    logic         changed;
    logic         wrap;

    int n_checks = 0;
    int n_fail   = 0;

    int m_q       = 0;
    int m_sout    = 0;
    int m_changed = 0;
    int m_wrap    = 0;

    universal_reg #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .mode(mode), .d(d), .sin(sin),
        .q(q), .qb(qb), .sout(sout), .changed(changed), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_q"},       {24'h0, q},         m_q);
        check({tag, "_qb"},      {24'h0, qb},        255 - m_q);
        check({tag, "_sout"},    {31'h0, sout},      m_sout);
        check({tag, "_changed"}, {31'h0, changed},   m_changed);
        check({tag, "_wrap"},    {31'h0, wrap},      m_wrap);
    endtask

    task automatic model_reset();
        m_q = 0; m_sout = 0; m_changed = 0; m_wrap = 0;
    endtask

    // Reference behaviour written as modular arithmetic on integers.
    task automatic model_edge();
        int oq;
        int nq;
        oq = m_q;
        nq = oq;
        m_wrap = 0;
        if (clr) begin
            nq = 0;
            m_sout = 0;
        end else if (en) begin
            case (int'(mode))
                1: nq = int'(d);
                2: begin nq = (oq * 2 + int'(sin)) % 256;  m_sout = oq / 128; end
                3: begin nq = oq / 2 + int'(sin) * 128;    m_sout = oq % 2;   end
                4: begin nq = (oq * 2) % 256 + oq / 128;   m_sout = oq / 128; end
                5: begin nq = oq / 2 + (oq % 2) * 128;     m_sout = oq % 2;   end
                6: begin nq = (oq + 1) % 256;   m_wrap = (oq == 255) ? 1 : 0; end
                7: begin nq = (oq + 255) % 256; m_wrap = (oq == 0) ? 1 : 0;   end
                default: nq = oq;
            endcase
        end
        m_changed = (nq != oq) ? 1 : 0;
        m_q = nq;
    endtask

    task automatic op(input string tag, input logic e, input logic c, input logic [2:0] md,
                      input logic [W-1:0] dd, input logic s);
        en = e; clr = c; mode = md; d = dd; sin = s;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Called at posedge+1: pulses reset in the middle of the cycle, checks outputs before
    // the next edge, and releases it so the following edge runs normally.
    task automatic mid_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; en = 1'b0; clr = 1'b0; mode = 3'b000; d = 8'h00; sin = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        check_all("por");
        reset = 1'b0;

        // Load, then identical load must not pulse changed.
        op("ld_a5", 1'b1, 1'b0, 3'b001, 8'hA5, 1'b0);
        check("ld_a5_const", {24'h0, qb}, 32'h5A);
        op("ld_a5_again", 1'b1, 1'b0, 3'b001, 8'hA5, 1'b0);
        check("ld_same_nochg", {31'h0, changed}, 32'h0);

        // Shift / rotate boundary bits.
        op("ld_81", 1'b1, 1'b0, 3'b001, 8'h81, 1'b0);
        op("shl", 1'b1, 1'b0, 3'b010, 8'hFF, 1'b0);
        check("shl_const", {23'h0, q, sout}, {23'h0, 8'h02, 1'b1});
        op("rotr", 1'b1, 1'b0, 3'b101, 8'hFF, 1'b1);
        check("rotr_const", {23'h0, q, sout}, {23'h0, 8'h01, 1'b0});
        op("ld_80", 1'b1, 1'b0, 3'b001, 8'h80, 1'b0);
        op("rotl", 1'b1, 1'b0, 3'b100, 8'h00, 1'b0);
        check("rotl_const", {23'h0, q, sout}, {23'h0, 8'h01, 1'b1});
        op("shr", 1'b1, 1'b0, 3'b011, 8'h00, 1'b1);
        op("ld_ff", 1'b1, 1'b0, 3'b001, 8'hFF, 1'b0);
        op("rotl_uniform", 1'b1, 1'b0, 3'b100, 8'h00, 1'b0);

        // Increment/decrement wrap pulses.
        op("ld_fe", 1'b1, 1'b0, 3'b001, 8'hFE, 1'b0);
        op("inc1", 1'b1, 1'b0, 3'b110, 8'h00, 1'b0);
        op("inc2", 1'b1, 1'b0, 3'b110, 8'h00, 1'b0);
        check("inc_wrap_const", {23'h0, q, wrap}, {23'h0, 8'h00, 1'b1});
        op("dec", 1'b1, 1'b0, 3'b111, 8'h00, 1'b0);
        check("dec_wrap_const", {23'h0, q, wrap}, {23'h0, 8'hFF, 1'b1});
        op("hold", 1'b1, 1'b0, 3'b000, 8'h12, 1'b1);

        // Enable and clear priority.
        op("ld_3c", 1'b1, 1'b0, 3'b001, 8'h3C, 1'b0);
        op("en0", 1'b0, 1'b0, 3'b110, 8'h00, 1'b0);
        op("clr_en0", 1'b0, 1'b1, 3'b110, 8'h00, 1'b0);
        check("clr_chg_const", {23'h0, q, changed}, {23'h0, 8'h00, 1'b1});
        op("clr_again", 1'b0, 1'b1, 3'b000, 8'h00, 1'b0);
        op("ld_81b", 1'b1, 1'b0, 3'b001, 8'h81, 1'b0);
        op("shl_b", 1'b1, 1'b0, 3'b010, 8'h00, 1'b1);
        op("clr_vs_load", 1'b1, 1'b1, 3'b001, 8'h77, 1'b0);

        // Reset while incrementing.
        op("ld_10", 1'b1, 1'b0, 3'b001, 8'h10, 1'b0);
        en = 1'b1; clr = 1'b0; mode = 3'b110;
        mid_reset("rst_inc");
        op("after_rst", 1'b1, 1'b0, 3'b110, 8'h00, 1'b0);

        // Randomised traffic with occasional mid-cycle resets.
        for (int i = 0; i < 600; i++) begin
            op("rnd", ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
               3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 49) == 0) mid_reset("rnd_rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
